// File: rtl/regex_instruction_memory_server_if.sv
// Fetch/load bus between regex CPU fetch ports, the program loader and the shared
// instruction memory. master = requesters/loader side, slave = memory server side.
interface regex_instruction_memory_server_if #(
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int NUM_PORTS         = 2
);
    logic [NUM_PORTS-1:0]                   memory_valid;
    logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
    logic [NUM_PORTS-1:0]                   memory_ready;
    logic [MEMORY_WIDTH-1:0]                memory_data;
    logic                                   load_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]           load_addr;
    logic [MEMORY_WIDTH-1:0]                load_data;
    logic                                   load_ready;

    modport master (
        output memory_valid, memory_addr, load_valid, load_addr, load_data,
        input  memory_ready, memory_data, load_ready
    );

    modport slave (
        input  memory_valid, memory_addr, load_valid, load_addr, load_data,
        output memory_ready, memory_data, load_ready
    );
endinterface

// File: rtl/regex_instruction_memory_server.sv
// Shared single-port instruction RAM with round-robin fetch arbitration and a load port.
// Define INSTR_MEM_OUTPUT_REG_EN to add a RAM output register stage (PIPE state).
module regex_instruction_memory_server #(
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int NUM_PORTS         = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    regex_instruction_memory_server_if.slave        bus,
    output logic                                    busy
);
    localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef INSTR_MEM_OUTPUT_REG_EN
    typedef enum logic [1:0] {S_IDLE, S_READ, S_PIPE, S_RESP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;
`endif

    state_t                       r_state;
    state_t                       w_next_state;
    logic [PTR_W-1:0]             r_rr_ptr;
    logic [PTR_W-1:0]             r_grant;
    logic [PTR_W-1:0]             w_grant_idx;
    logic [PTR_W-1:0]             w_next_ptr;
    logic                         w_grant_found;
    logic                         w_grant_fire;
    logic                         w_load_fire;
    logic [MEMORY_ADDR_WIDTH-1:0] w_grant_addr;
    logic [MEMORY_ADDR_WIDTH-1:0] r_addr;
    logic [MEMORY_WIDTH-1:0]      r_mem [DEPTH];
    logic [MEMORY_WIDTH-1:0]      r_data;
`ifdef INSTR_MEM_OUTPUT_REG_EN
    logic [MEMORY_WIDTH-1:0]      r_pipe;
`endif

    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        int               v_idx;
        logic [PTR_W-1:0] v_cand;
        v_idx         = 0;
        v_cand        = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_grant_addr  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_PORTS) begin
                v_idx = v_idx - NUM_PORTS;
            end
            v_cand = PTR_W'(v_idx);
            if (!w_grant_found && bus.memory_valid[v_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_cand;
                w_grant_addr  = bus.memory_addr[int'(v_cand)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        if (int'(w_grant_idx) == NUM_PORTS - 1) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_grant_idx + 1'b1;
        end
    end

    // Next-state logic; a pending load always takes the IDLE cycle ahead of a fetch.
    always_comb begin
        w_next_state = r_state;
        w_load_fire  = 1'b0;
        w_grant_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_valid) begin
                    w_load_fire = !rst;
                end else if (w_grant_found) begin
                    w_grant_fire = 1'b1;
                    w_next_state = S_READ;
                end
            end
`ifdef INSTR_MEM_OUTPUT_REG_EN
            S_READ:  w_next_state = S_PIPE;
            S_PIPE:  w_next_state = S_RESP;
`else
            S_READ:  w_next_state = S_RESP;
`endif
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_fire) begin
                r_grant  <= w_grant_idx;
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    // Latched fetch address acts as the RAM's registered read address.
    always_ff @(posedge clk) begin
        if (w_grant_fire) begin
            r_addr <= w_grant_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
`ifdef INSTR_MEM_OUTPUT_REG_EN
        if (r_state == S_READ) begin
            r_pipe <= r_mem[r_addr];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
`ifdef INSTR_MEM_OUTPUT_REG_EN
        end else if (r_state == S_PIPE) begin
            r_data <= r_pipe;
`else
        end else if (r_state == S_READ) begin
            r_data <= r_mem[r_addr];
`endif
        end
    end

    always_comb begin
        bus.memory_ready = '0;
        if (r_state == S_RESP) begin
            bus.memory_ready[r_grant] = 1'b1;
        end
    end

    assign bus.memory_data = r_data;
    assign bus.load_ready  = (r_state == S_IDLE) && !rst;
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_regex_instruction_memory_server.sv
// Directed and randomized bench for regex_instruction_memory_server against a
// transaction-level model (memory array, round-robin pointer, fixed service timing).
module tb_regex_instruction_memory_server;
    localparam int MW = 20;
    localparam int AW = 11;
    localparam int NP = 2;
`ifdef INSTR_MEM_OUTPUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;

    regex_instruction_memory_server_if #(
        .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW), .NUM_PORTS(NP)
    ) bus ();

    regex_instruction_memory_server #(
        .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW), .NUM_PORTS(NP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    int           m_ptr = 0;
    logic [MW-1:0] m_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.memory_valid = '0;
        bus.load_valid   = 1'b0;
        tick();
        check("rst_ready", 32'(bus.memory_ready), 32'd0);
        check("rst_data", 32'(bus.memory_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        rst   = 1'b0;
        m_ptr = 0;
        #1;
        check("load_ready_after_rst", 32'(bus.load_ready), 32'd1);
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [MW-1:0] d);
        check("load_ready_idle", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_data  = d;
        tick();
        bus.load_valid = 1'b0;
        m_mem[int'(a)] = d;
        check("load_busy", 32'(busy), 32'd0);
    endtask

    // Requesters hold valid until they see ready, then drop it after that cycle
    // (rereq ports keep requesting). Expected grant order comes from the RR rule.
    task automatic serve(input string tag, input logic [NP-1:0] mask, input logic [NP-1:0] rereq,
                         input int nresp, input int ldelay,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int            order[$];
        logic [NP-1:0] pend;
        logic [NP-1:0] drop;
        logic [NP-1:0] expv;
        logic [AW-1:0] addr [NP];
        int            total;
        int            k;
        int            w;
        int            p;
        addr[0] = a0;
        addr[1] = a1;
        pend    = mask;
        for (int n = 0; n < nresp; n++) begin
            w = -1;
            for (int s = 0; s < NP; s++) begin
                p = (m_ptr + s) % NP;
                if (w < 0 && pend[p]) w = p;
            end
            order.push_back(w);
            m_ptr = (w + 1) % NP;
            if (!rereq[w]) pend[w] = 1'b0;
        end

        bus.memory_addr  = {a1, a0};
        bus.memory_valid = mask;
        drop  = '0;
        total = ldelay + nresp * (LAT + 1) + 1;
        for (int c = 0; c < total; c++) begin
            tick();
            bus.memory_valid = bus.memory_valid & ~drop;
            drop = '0;
            if (c == 0) bus.load_valid = 1'b0;
            if (c == ldelay) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_load_ready_busy"}, 32'(bus.load_ready), 32'd0);
            end
            k    = c - ldelay - (LAT - 1);
            expv = '0;
            w    = -1;
            if (k >= 0 && (k % (LAT + 1)) == 0 && (k / (LAT + 1)) < nresp) begin
                w       = order[k / (LAT + 1)];
                expv[w] = 1'b1;
            end
            check({tag, "_ready"}, 32'(bus.memory_ready), 32'(expv));
            if (w >= 0) begin
                check({tag, "_data"}, 32'(bus.memory_data), 32'(m_mem[int'(addr[w])]));
                if ((k / (LAT + 1)) == nresp - 1) drop = '1;
                else if (!rereq[w]) drop[w] = 1'b1;
            end
        end
        bus.memory_valid = bus.memory_valid & ~drop;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.memory_valid = '0;
        bus.memory_addr  = '0;
        bus.load_valid   = 1'b0;
        bus.load_addr    = '0;
        bus.load_data    = '0;
        do_reset();

        // Single fetch after program load.
        do_load(11'h0DC, 20'h30041);
        do_load(11'h0DD, 20'h30042);
        serve("single", 2'b01, 2'b00, 1, 0, 11'h0DD, 11'h000);

        // Both ports requesting continuously from reset: 0,1,0,1.
        do_reset();
        serve("rr_cont", 2'b11, 2'b11, 4, 0, 11'h0DC, 11'h0DD);

        // Load and fetch of the same address rise together.
        do_load(11'h100, 20'h12345);
        bus.load_valid = 1'b1;
        bus.load_addr  = 11'h100;
        bus.load_data  = 20'hABCDE;
        check("conflict_load_ready", 32'(bus.load_ready), 32'd1);
        m_mem[32'h100] = 20'hABCDE;
        serve("load_vs_fetch", 2'b10, 2'b00, 1, 1, 11'h000, 11'h100);

        // Reset while READ after granting port 0 (pointer would otherwise point at 1).
        bus.memory_addr  = {11'h0DD, 11'h0DC};
        bus.memory_valid = 2'b01;
        tick();
        check("rstread_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rstread_ready", 32'(bus.memory_ready), 32'd0);
        check("rstread_busy_low", 32'(busy), 32'd0);
        bus.memory_valid = '0;
        rst   = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check("rstread_no_pulse", 32'(bus.memory_ready), 32'd0);
        end
        serve("after_rst", 2'b11, 2'b00, 2, 0, 11'h0DC, 11'h0DD);

        // Randomized programs and request masks.
        for (int it = 0; it < 24; it++) begin
            logic [AW-1:0] ra0;
            logic [AW-1:0] ra1;
            logic [NP-1:0] rm;
            int            nr;
            ra0 = AW'($urandom);
            ra1 = AW'($urandom);
            if ($urandom_range(0, 3) == 0) ra1 = ra0;
            do_load(ra0, MW'($urandom));
            do_load(ra1, MW'($urandom));
            rm = NP'($urandom_range(1, 3));
            nr = (rm == 2'b11) ? 2 : 1;
            serve("rand", rm, 2'b00, nr, 0, ra0, ra1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regex_instruction_memory_server.md
# regex_instruction_memory_server

Shared instruction memory serving the fetch ports of one or more `regex_cpu_pipelined` instances. It is the responder side of the CPU fetch handshake (`memory_valid`/`memory_addr` in, `memory_ready`/`memory_data` out). A round-robin arbiter serialises requests onto one single-port RAM. A load port writes the regex program before or between runs.

## Interface
Parameters:
- `MEMORY_WIDTH`, 20, instruction word width.
- `MEMORY_ADDR_WIDTH`, 11, address width; RAM depth is 2**`MEMORY_ADDR_WIDTH`.
- `NUM_PORTS`, 2, number of CPU fetch ports (≥1).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memory_valid` in `NUM_PORTS`: per-port fetch request.
- `memory_addr` in `NUM_PORTS*MEMORY_ADDR_WIDTH`: per-port address; port i uses bits [i*W +: W].
- `memory_ready` out `NUM_PORTS`: per-port one-cycle response strobe.
- `memory_data` out `MEMORY_WIDTH`: response word, broadcast to all ports, valid only while some `memory_ready` bit is high.
- `load_valid` in 1: program write request.
- `load_addr` in `MEMORY_ADDR_WIDTH`: write address.
- `load_data` in `MEMORY_WIDTH`: write word.
- `load_ready` out 1: write accepted when high together with `load_valid`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, READ, RESP. Under `INSTR_MEM_OUTPUT_REG_EN` it adds a fourth state, PIPE.
- IDLE:
  - If `load_valid` is high, the RAM is written at the edge and the FSM stays in IDLE. Load always beats fetch.
  - Otherwise, if any `memory_valid` bit is high, the arbiter grants one port. It latches the port index and address, issues the RAM read, and goes to READ.
- READ: the RAM output is captured into `memory_data`. Next state is RESP, or PIPE when the macro is defined.
- PIPE (macro only): one extra register stage, then RESP.
- RESP:
  - `memory_ready[granted]` = 1 for exactly this cycle; every other bit is 0.
  - `memory_data` holds the word.
  - Next state is IDLE.
  - `memory_valid` is ignored in RESP. The requester still shows valid during its ready cycle and drops it afterwards, so it cannot be double-served.
- Requester rule: a port holds `memory_valid` and `memory_addr` stable from assertion until it samples `memory_ready` high. A changed address before service is a protocol error and is not checked.
- Arbitration: round-robin priority pointer `rr_ptr`.
  - Search starts at `rr_ptr`. The first requesting port in ascending index order, modulo `NUM_PORTS`, wins.
  - After the grant, `rr_ptr` = (granted+1) mod `NUM_PORTS`.
  - The pointer does not move on load cycles.
- `load_ready` = (state == IDLE) && !`rst`.
- A write and a read never share a RAM cycle.
- Reading an address in the same cycle it is written is impossible, because a load blocks the grant. A fetch granted in the cycle after a write to the same address returns the new data.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0
  - `memory_ready` all 0, `memory_data` 0
  - `busy` 0, `load_ready` 0 during the reset cycle, then 1
  - RAM contents are not reset.
- Latency: request sampled at edge t, then `memory_ready` is high during cycle t+2 (t+3 with the macro).
- Throughput: one fetch per 3 cycles (4 with the macro), counting the return to IDLE.
- Simultaneous `load_valid` and `memory_valid` in IDLE: the write is performed and the fetch waits. It is granted at the first IDLE edge with `load_valid` low.
- Continuous `load_valid` starves fetches. This is intentional: programs are loaded only while the CPUs are idle.
- Reset mid-operation: the in-flight read is dropped and no `memory_ready` pulse occurs. The requester must re-request after reset.
- `NUM_PORTS` = 1: the pointer stays 0 and behaviour reduces to a single responder.

## Configuration
- `INSTR_MEM_OUTPUT_REG_EN` defined:
  - Adds the PIPE state and an output register between the RAM and `memory_data`, for BRAM output-register timing closure.
  - Response latency is 3 cycles after the request edge; one fetch per 4 cycles.
- Not defined: latency is 2 cycles; one fetch per 3 cycles. All other behaviour is identical.

## Test plan
- Load the words 0x3_0041 at address 0x0DC and 0x3_0042 at 0x0DD. Port 0 requests 0x0DD. Expect `memory_ready` = 2'b01 for exactly one cycle, two cycles after the request edge, with `memory_data` = 0x3_0042.
- Ports 0 and 1 both request continuously after reset. Expect grants in the order 0, 1, 0, 1, with a `memory_ready` pulse every 3 cycles, and never two bits high at once.
- `load_valid` and `memory_valid[1]` rise in the same cycle, both targeting address 0x100 with new data 0xABCDE. Expect the write to occur first and the fetch to return 0xABCDE one cycle later than the unloaded latency.
- Assert `rst` during READ. Expect no `memory_ready` pulse, `busy` = 0 the next cycle, and `rr_ptr` back at 0, so port 0 wins the next contested grant.
- With `INSTR_MEM_OUTPUT_REG_EN`, repeat scenario 1. Expect the ready pulse three cycles after the request edge with the same data.
- After servicing port 0, keep its `memory_valid` high during the RESP cycle only, then drop it. Expect exactly one response, with no second grant to port 0.
